// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write-through bypass
// and a per-register pending-write scoreboard for issue-stage stalls.
module regfile_mp_sb #(
   parameter  int XLEN     = 32,
   parameter  int NREG     = 32,
   parameter  int NRD      = 2,
   parameter  int NWR      = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic                iss_ok,
   output logic [NREG-1:0]     busy_vec
);

   localparam bit ZR = (ZERO_REG != 0);

   logic [XLEN-1:0] mem_q [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NWR-1:0]  wr_eff;
   logic            iss_hit;
   logic            iss_zero;
   logic            iss_acc;

   always_comb begin
      wr_eff = '0;
      for (int j = 0; j < NWR; j++)
         wr_eff[j] = wr_en[j] && !(ZR && wr_addr[j*AW +: AW] == '0);
   end

   // Ascending scan: the highest-indexed matching write port wins.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic            hit;
      logic [XLEN-1:0] byp;

      assign ra = rd_addr[i*AW +: AW];

      always_comb begin
         hit = 1'b0;
         byp = '0;
         for (int j = 0; j < NWR; j++) begin
            if (wr_eff[j] && wr_addr[j*AW +: AW] == ra) begin
               hit = 1'b1;
               byp = wr_data[j*XLEN +: XLEN];
            end
         end
      end

      assign rd_data[i*XLEN +: XLEN] =
         (ZR && ra == '0) ? '0 : (hit ? byp : mem_q[ra]);
      assign rd_busy[i] = busy_q[ra] && !hit && !(ZR && ra == '0);
   end

   always_comb begin
      iss_hit = 1'b0;
      for (int j = 0; j < NWR; j++)
         if (wr_eff[j] && wr_addr[j*AW +: AW] == iss_addr)
            iss_hit = 1'b1;
   end

   assign iss_zero = ZR && iss_addr == '0;
   assign iss_ok   = iss_zero || !busy_q[iss_addr] || iss_hit;
   assign iss_acc  = iss_en && iss_ok && !iss_zero;

   // A new producer supersedes the one writing back.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NWR; j++)
         if (wr_eff[j])
            busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      if (iss_acc)
         busy_d[iss_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++)
            mem_q[r] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++)
            if (wr_eff[j])
               mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed and random checks of two regfile_mp_sb
// configurations against an array-based reference model.
module tb_regfile_mp_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [9:0]  a_rd_addr;
   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic [1:0]  a_wr_en;
   logic [9:0]  a_wr_addr;
   logic [63:0] a_wr_data;
   logic        a_iss_en;
   logic [4:0]  a_iss_addr;
   logic        a_iss_ok;
   logic [31:0] a_busy_vec;

   logic [8:0]  b_rd_addr;
   logic [47:0] b_rd_data;
   logic [2:0]  b_rd_busy;
   logic [0:0]  b_wr_en;
   logic [2:0]  b_wr_addr;
   logic [15:0] b_wr_data;
   logic        b_iss_en;
   logic [2:0]  b_iss_addr;
   logic        b_iss_ok;
   logic [7:0]  b_busy_vec;

   regfile_mp_sb u_a (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .iss_en(a_iss_en), .iss_addr(a_iss_addr), .iss_ok(a_iss_ok),
      .busy_vec(a_busy_vec)
   );

   regfile_mp_sb #(
      .XLEN(16), .NREG(8), .NRD(3), .NWR(1), .ZERO_REG(0)
   ) u_b (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .iss_en(b_iss_en), .iss_addr(b_iss_addr), .iss_ok(b_iss_ok),
      .busy_vec(b_busy_vec)
   );

   int checks = 0;
   int errors = 0;

   int          cfg_nreg [2] = '{32, 8};
   int          cfg_nrd  [2] = '{2, 3};
   int          cfg_nwr  [2] = '{2, 1};
   int          cfg_zr   [2] = '{1, 0};
   logic [31:0] cfg_xm   [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

   logic [31:0] m_mem  [2][32];
   bit          m_busy [2][32];

   bit          s_we [2][2];
   int unsigned s_wa [2][2];
   logic [31:0] s_wd [2][2];
   int unsigned s_ra [2][3];
   bit          s_ie [2];
   int unsigned s_ia [2];

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned am(int k, int unsigned a);
      return a & (cfg_nreg[k] - 1);
   endfunction

   function automatic bit eff(int k, int j);
      return s_we[k][j] && !(cfg_zr[k] != 0 && am(k, s_wa[k][j]) == 0);
   endfunction

   function automatic bit whit(int k, int unsigned a);
      bit h = 1'b0;
      for (int j = 0; j < cfg_nwr[k]; j++)
         if (eff(k, j) && am(k, s_wa[k][j]) == a) h = 1'b1;
      return h;
   endfunction

   function automatic logic [31:0] exp_rd(int k, int unsigned a);
      logic [31:0] d = m_mem[k][a];
      if (cfg_zr[k] != 0 && a == 0) return 32'h0;
      for (int j = 0; j < cfg_nwr[k]; j++)
         if (eff(k, j) && am(k, s_wa[k][j]) == a) d = s_wd[k][j] & cfg_xm[k];
      return d;
   endfunction

   function automatic bit exp_busy(int k, int unsigned a);
      return m_busy[k][a] && !whit(k, a) && !(cfg_zr[k] != 0 && a == 0);
   endfunction

   function automatic bit exp_ok(int k);
      int unsigned a = am(k, s_ia[k]);
      return (cfg_zr[k] != 0 && a == 0) || !m_busy[k][a] || whit(k, a);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 32; r++) begin
            m_mem[k][r]  = 32'h0;
            m_busy[k][r] = 1'b0;
         end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int unsigned ia = am(k, s_ia[k]);
         bit acc = s_ie[k] && exp_ok(k) && !(cfg_zr[k] != 0 && ia == 0);
         for (int j = 0; j < cfg_nwr[k]; j++)
            if (eff(k, j)) begin
               m_mem[k][am(k, s_wa[k][j])]  = s_wd[k][j] & cfg_xm[k];
               m_busy[k][am(k, s_wa[k][j])] = 1'b0;
            end
         if (acc) m_busy[k][ia] = 1'b1;
      end
   endtask

   task automatic idle();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 2; j++) begin
            s_we[k][j] = 1'b0; s_wa[k][j] = 0; s_wd[k][j] = 32'h0;
         end
         for (int i = 0; i < 3; i++) s_ra[k][i] = 0;
         s_ie[k] = 1'b0; s_ia[k] = 0;
      end
   endtask

   task automatic set_wr(int j, int unsigned a, logic [31:0] d);
      for (int k = 0; k < 2; k++)
         if (j < cfg_nwr[k]) begin
            s_we[k][j] = 1'b1; s_wa[k][j] = a; s_wd[k][j] = d;
         end
   endtask

   task automatic set_rd(int i, int unsigned a);
      for (int k = 0; k < 2; k++)
         if (i < cfg_nrd[k]) s_ra[k][i] = a;
   endtask

   task automatic set_iss(int unsigned a);
      for (int k = 0; k < 2; k++) begin
         s_ie[k] = 1'b1; s_ia[k] = a;
      end
   endtask

   task automatic drive();
      for (int j = 0; j < 2; j++) begin
         a_wr_en[j]           = s_we[0][j];
         a_wr_addr[j*5 +: 5]  = 5'(s_wa[0][j]);
         a_wr_data[j*32 +: 32] = s_wd[0][j];
      end
      for (int i = 0; i < 2; i++) a_rd_addr[i*5 +: 5] = 5'(s_ra[0][i]);
      a_iss_en   = s_ie[0];
      a_iss_addr = 5'(s_ia[0]);
      b_wr_en[0] = s_we[1][0];
      b_wr_addr  = 3'(s_wa[1][0]);
      b_wr_data  = 16'(s_wd[1][0]);
      for (int i = 0; i < 3; i++) b_rd_addr[i*3 +: 3] = 3'(s_ra[1][i]);
      b_iss_en   = s_ie[1];
      b_iss_addr = 3'(s_ia[1]);
   endtask

   task automatic check_all(string ph);
      for (int k = 0; k < 2; k++) begin
         logic [31:0] bv = 32'h0;
         logic [63:0] got;
         for (int i = 0; i < cfg_nrd[k]; i++) begin
            int unsigned a = am(k, s_ra[k][i]);
            got = (k == 0) ? 64'(a_rd_data[i*32 +: 32])
                           : 64'(b_rd_data[i*16 +: 16]);
            chk($sformatf("%s.k%0d.rd%0d.data", ph, k, i), got, 64'(exp_rd(k, a)));
            got = (k == 0) ? 64'(a_rd_busy[i]) : 64'(b_rd_busy[i]);
            chk($sformatf("%s.k%0d.rd%0d.busy", ph, k, i), got, 64'(exp_busy(k, a)));
         end
         got = (k == 0) ? 64'(a_iss_ok) : 64'(b_iss_ok);
         chk($sformatf("%s.k%0d.iss_ok", ph, k), got, 64'(exp_ok(k)));
         for (int r = 0; r < cfg_nreg[k]; r++) bv[r] = m_busy[k][r];
         got = (k == 0) ? 64'(a_busy_vec) : 64'(b_busy_vec);
         chk($sformatf("%s.k%0d.busy_vec", ph, k), got, 64'(bv));
      end
   endtask

   task automatic cycle(string ph);
      drive();
      #2;
      check_all(ph);
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   function automatic int unsigned rnd_addr();
      return ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                         : $urandom_range(0, 7);
   endfunction

   initial begin
      rst_n = 1'b1;
      idle();
      drive();
      #1 rst_n = 1'b0;
      model_reset();
      @(negedge clk);

      // reset state, and bypass still live while in reset
      cycle("rst");
      idle(); set_wr(0, 4, 32'hCAFE_F00D); set_rd(0, 4); set_iss(4);
      cycle("rst_byp");
      rst_n = 1'b1;
      idle(); set_rd(0, 4); set_rd(1, 4);
      cycle("rst_rel");

      // same-cycle double write: highest port wins
      idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22);
      set_rd(0, 7); set_rd(1, 7);
      cycle("prio");
      idle(); set_rd(0, 7); set_rd(1, 7); set_rd(2, 7);
      cycle("prio_st");

      // register 0: hardwired in u_a, ordinary in u_b
      idle(); set_wr(0, 0, 32'hFFFF_FFFF); set_iss(0); set_rd(0, 0);
      cycle("zero");
      idle(); set_rd(0, 0); set_rd(1, 0); set_iss(0);
      cycle("zero_nx");

      // RAW on r3
      idle(); set_iss(3);
      cycle("raw_iss");
      idle(); set_rd(0, 3); set_rd(2, 3);
      cycle("raw_busy");
      idle(); set_wr(0, 3, 32'h55); set_rd(0, 3); set_rd(1, 3);
      cycle("raw_wb");
      idle(); set_rd(0, 3);
      cycle("raw_clr");

      // WAW / issue collision on r9
      idle(); set_iss(9);
      cycle("waw_iss");
      idle(); set_iss(9); set_rd(1, 9);
      cycle("waw_rej");
      idle(); set_iss(9); set_wr(0, 9, 32'h99); set_rd(0, 9);
      cycle("waw_col");
      idle(); set_rd(0, 9);
      cycle("waw_after");

      // asynchronous reset between edges
      idle(); set_wr(0, 5, 32'hDEAD_BEEF); set_iss(5);
      cycle("mr_wr");
      idle(); set_rd(0, 5); set_rd(1, 5);
      drive();
      #2;
      check_all("mr_pre");
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check_all("mr_rst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("mr_post");

      for (int n = 0; n < 600; n++) begin
         int unsigned wa0 = rnd_addr();
         int unsigned wa1 = $urandom_range(0, 1) ? wa0 : rnd_addr();
         idle();
         for (int k = 0; k < 2; k++) begin
            s_we[k][0] = 1'($urandom_range(0, 1));
            s_we[k][1] = 1'($urandom_range(0, 1));
            s_wa[k][0] = wa0;
            s_wa[k][1] = wa1;
         end
         s_wd[0][0] = $urandom(); s_wd[1][0] = s_wd[0][0];
         s_wd[0][1] = $urandom(); s_wd[1][1] = s_wd[0][1];
         for (int i = 0; i < 3; i++) set_rd(i, rnd_addr());
         if ($urandom_range(0, 2) != 0) set_iss(rnd_addr());
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         cycle($sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
